// File: rtl/usb_tx_sched.sv
// USB transmit scheduler: arbitrates handshake vs. data requesters, issues one
// packet command at a time, tracks TX_Transfer_Active and enforces a turnaround gap.
module usb_tx_sched #(
   parameter int START_TIMEOUT = 16,
   parameter int TURNAROUND    = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       hs_req,
   input  logic [1:0] hs_code,
   output logic       hs_done,
   output logic       hs_err,
   input  logic       data_req,
   input  logic       data_pid,
   output logic       data_done,
   output logic       data_err,
   output logic [2:0] tx_packet,
   input  logic       TX_Transfer_Active,
   input  logic       tx_error,
   output logic       sched_busy,
   output logic       grant_hs
);

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT_START, ACTIVE, DONE, GAP} state_t;

   localparam logic [7:0] TO_LAST  = 8'(START_TIMEOUT - 1);
   localparam logic [3:0] GAP_LAST = 4'(TURNAROUND - 1);

   state_t     state_q, state_d;
   logic [2:0] cmd_q, cmd_d;
   logic       grant_q, grant_d;
   logic       err_q, err_d;
   logic [7:0] to_cnt_q, to_cnt_d;
   logic [3:0] gap_cnt_q, gap_cnt_d;
   logic [2:0] tx_packet_q, tx_packet_d;
   logic       hs_done_q, hs_done_d, hs_err_q, hs_err_d;
   logic       data_done_q, data_done_d, data_err_q, data_err_d;
   logic       busy_q, busy_d, grant_hs_q, grant_hs_d;

   always_comb begin
      state_d   = state_q;
      cmd_d     = cmd_q;
      grant_d   = grant_q;
      err_d     = err_q;
      to_cnt_d  = to_cnt_q;
      gap_cnt_d = gap_cnt_q;
      case (state_q)
         IDLE: begin
            if (hs_req) begin
               grant_d = 1'b1;
               cmd_d   = 3'(hs_code) + 3'd3;
               err_d   = (hs_code == 2'd3);
               state_d = (hs_code == 2'd3) ? DONE : ISSUE;
            end else if (data_req) begin
               grant_d = 1'b0;
               cmd_d   = data_pid ? 3'd2 : 3'd1;
               err_d   = 1'b0;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            to_cnt_d = 8'd0;
            if (tx_error) err_d = 1'b1;
            state_d = WAIT_START;
         end
         WAIT_START: begin
            if (tx_error) err_d = 1'b1;
            if (to_cnt_q != 8'hFF) to_cnt_d = to_cnt_q + 8'd1;
            // A start seen on the last allowed cycle still wins over the timeout.
            if (TX_Transfer_Active) begin
               state_d = ACTIVE;
            end else if (to_cnt_q >= TO_LAST) begin
               err_d   = 1'b1;
               state_d = DONE;
            end
         end
         ACTIVE: begin
            if (tx_error) err_d = 1'b1;
            if (!TX_Transfer_Active) state_d = DONE;
         end
         DONE: begin
            gap_cnt_d = 4'd0;
            state_d   = GAP;
         end
         GAP: begin
            if (gap_cnt_q >= GAP_LAST) state_d = IDLE;
            else                       gap_cnt_d = gap_cnt_q + 4'd1;
         end
         default: state_d = IDLE;
      endcase

      // Outputs are registered from next-state so they line up with the state they describe.
      tx_packet_d = (state_d == ISSUE) ? cmd_d : 3'd0;
      hs_done_d   = (state_d == DONE) && grant_d;
      hs_err_d    = (state_d == DONE) && grant_d && err_d;
      data_done_d = (state_d == DONE) && !grant_d;
      data_err_d  = (state_d == DONE) && !grant_d && err_d;
      busy_d      = (state_d != IDLE);
      grant_hs_d  = grant_d && (state_d != IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cmd_q       <= 3'd0;
         grant_q     <= 1'b0;
         err_q       <= 1'b0;
         to_cnt_q    <= 8'd0;
         gap_cnt_q   <= 4'd0;
         tx_packet_q <= 3'd0;
         hs_done_q   <= 1'b0;
         hs_err_q    <= 1'b0;
         data_done_q <= 1'b0;
         data_err_q  <= 1'b0;
         busy_q      <= 1'b0;
         grant_hs_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cmd_q       <= cmd_d;
         grant_q     <= grant_d;
         err_q       <= err_d;
         to_cnt_q    <= to_cnt_d;
         gap_cnt_q   <= gap_cnt_d;
         tx_packet_q <= tx_packet_d;
         hs_done_q   <= hs_done_d;
         hs_err_q    <= hs_err_d;
         data_done_q <= data_done_d;
         data_err_q  <= data_err_d;
         busy_q      <= busy_d;
         grant_hs_q  <= grant_hs_d;
      end
   end

   assign tx_packet  = tx_packet_q;
   assign hs_done    = hs_done_q;
   assign hs_err     = hs_err_q;
   assign data_done  = data_done_q;
   assign data_err   = data_err_q;
   assign sched_busy = busy_q;
   assign grant_hs   = grant_hs_q;

endmodule
